// File: rtl/simple_dpram_sclk.sv
// ----------------------------------------------------------------------------
// simple_dpram_sclk : single-clock simple dual-port RAM, registered read
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter     ENABLE_BYPASS = "TRUE"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  // Bypass forwards a same-cycle write to the read port instead of the old word.
  generate
    if (ENABLE_BYPASS == "TRUE") begin : g_bypass
      assign dout_d = (we && (waddr == raddr)) ? din : mem[raddr];
    end else begin : g_no_bypass
      assign dout_d = mem[raddr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/fifo_fwft_sclk.sv
// ----------------------------------------------------------------------------
// fifo_fwft_sclk : single-clock first-word-fall-through FIFO controller
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_fwft_sclk #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ALMOST_FULL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_AFULL = PTR_W'(ALMOST_FULL);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] fill_level_q, fill_level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc;
  logic             rd_acc;

  always_comb begin
    wr_acc        = wr_en && !full_q;
    rd_acc        = rd_en && !empty_q;
    wr_ptr_d      = wr_acc ? wr_ptr_q + C_ONE : wr_ptr_q;
    rd_ptr_d      = rd_acc ? rd_ptr_q + C_ONE : rd_ptr_q;
    fill_level_d  = fill_level_q;
    if (wr_acc && !rd_acc) begin
      fill_level_d = fill_level_q + C_ONE;
    end else if (rd_acc && !wr_acc) begin
      fill_level_d = fill_level_q - C_ONE;
    end
    // Flags come from the next count so they change on the causing edge.
    empty_d       = (fill_level_d == '0);
    full_d        = (fill_level_d == C_DEPTH);
    almost_full_d = (fill_level_d >= C_AFULL);
    overflow_d    = overflow_q  || (wr_en && full_q);
    underflow_d   = underflow_q || (rd_en && empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_level_q  <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_level_q  <= fill_level_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Reading at the next read pointer keeps dout equal to mem[rd_ptr] after every edge.
  simple_dpram_sclk #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS ("TRUE")
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .din   (din),
    .raddr (rd_ptr_d[ADDR_WIDTH-1:0]),
    .dout  (dout)
  );

  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign empty       = empty_q;
  assign fill_level  = fill_level_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

`default_nettype wire
